// File: rtl/cam_ctrl_pkg.sv
// Shared definitions for the CAM access controller: opcodes, FSM states and default widths.
package cam_ctrl_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 4;

   localparam logic [1:0] OP_LOOKUP = 2'd0;
   localparam logic [1:0] OP_WRITE  = 2'd1;
   localparam logic [1:0] OP_ALLOC  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_e;

   // Opcode 3 is unassigned and falls back to a search.
   function automatic logic is_lookup(input logic [1:0] op);
      return (op != OP_WRITE) && (op != OP_ALLOC);
   endfunction

endpackage

// File: rtl/cam_rr_arb.sv
// Two-requester round-robin arbiter; last_grant only moves when the caller reports a transfer.
module cam_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_grant_q;
   logic last_grant_d;

   // Grant selection: a lone requester wins, a tie goes to the client not served last.
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Remember the winner of each completed transfer.
   always_comb begin
      last_grant_d = last_grant_q;
      if (advance) begin
         last_grant_d = grant[1];
      end else begin
         last_grant_d = last_grant_q;
      end
   end

   // Priority register; resets to 1 so client 0 takes the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/cam_access_ctrl.sv
// Arbitrated single-port sequencer in front of a 16x8 CAM (IDLE -> ISSUE -> CAPTURE).
// Optional feature: define CAM_AUTO_ALLOC_EN for occupancy-tracked ALLOC to the lowest free entry.
module cam_access_ctrl
   import cam_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [1:0]        op0,
   input  logic [1:0]        op1,
   input  logic [DATA_W-1:0] din0,
   input  logic [DATA_W-1:0] din1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   output logic [1:0]        ready,
   output logic              resp_valid,
   output logic              resp_id,
   output logic              resp_hit,
   output logic [ADDR_W-1:0] resp_addr,
   output logic              cam_wen,
   output logic              cam_ren,
   output logic [DATA_W-1:0] cam_din,
   output logic [ADDR_W-1:0] cam_addr,
   input  logic [ADDR_W-1:0] cam_dout,
   input  logic              cam_hit
);

   localparam int N = 2**ADDR_W;

   state_e            state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic              id_q, id_d;
   logic              fail_q, fail_d;
   logic              cam_wen_q, cam_wen_d;
   logic              cam_ren_q, cam_ren_d;
   logic [DATA_W-1:0] cam_din_q, cam_din_d;
   logic [ADDR_W-1:0] cam_addr_q, cam_addr_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_id_q, resp_id_d;
   logic              resp_hit_q, resp_hit_d;
   logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;

   logic [1:0]        grant;
   logic              transfer;
   logic              sel;
   logic [1:0]        op_sel;
   logic [DATA_W-1:0] din_sel;
   logic [ADDR_W-1:0] addr_sel;

`ifdef CAM_AUTO_ALLOC_EN
   logic [N-1:0]      occ_q, occ_d;
   logic [ADDR_W-1:0] free_idx;

   // Lowest-index free entry; only meaningful while the bitmap is not full.
   always_comb begin
      free_idx = {ADDR_W{1'b0}};
      for (int i = N - 1; i >= 0; i--) begin
         if (!occ_q[i]) begin
            free_idx = ADDR_W'(i);
         end else begin
            free_idx = free_idx;
         end
      end
   end
`endif

   cam_rr_arb u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (transfer),
      .grant   (grant)
   );

   assign sel      = grant[1];
   assign op_sel   = sel ? op1   : op0;
   assign din_sel  = sel ? din1  : din0;
   assign addr_sel = sel ? addr1 : addr0;

   // Next-state, handshake and CAM/response staging.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      id_d         = id_q;
      fail_d       = fail_q;
      cam_wen_d    = 1'b0;
      cam_ren_d    = 1'b0;
      cam_din_d    = cam_din_q;
      cam_addr_d   = cam_addr_q;
      resp_valid_d = 1'b0;
      resp_id_d    = resp_id_q;
      resp_hit_d   = resp_hit_q;
      resp_addr_d  = resp_addr_q;
      ready        = 2'b00;
      transfer     = 1'b0;
`ifdef CAM_AUTO_ALLOC_EN
      occ_d        = occ_q;
`endif
      case (state_q)
         ST_IDLE: begin
            ready    = req & grant;
            transfer = |(req & grant);
            if (transfer) begin
               state_d    = ST_ISSUE;
               op_d       = op_sel;
               id_d       = sel;
               fail_d     = 1'b0;
               cam_din_d  = din_sel;
               cam_addr_d = addr_sel;
               if (op_sel == OP_WRITE) begin
                  cam_wen_d = 1'b1;
`ifdef CAM_AUTO_ALLOC_EN
                  occ_d[addr_sel] = 1'b1;
`endif
               end else if (op_sel == OP_ALLOC) begin
`ifdef CAM_AUTO_ALLOC_EN
                  // A full table still walks ISSUE/CAPTURE so latency is unchanged.
                  if (&occ_q) begin
                     fail_d     = 1'b1;
                     cam_addr_d = {ADDR_W{1'b0}};
                  end else begin
                     cam_wen_d       = 1'b1;
                     cam_addr_d      = free_idx;
                     occ_d[free_idx] = 1'b1;
                  end
`else
                  cam_wen_d = 1'b1;
`endif
               end else begin
                  cam_ren_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            state_d      = ST_IDLE;
            resp_valid_d = 1'b1;
            resp_id_d    = id_q;
            if (is_lookup(op_q)) begin
               resp_hit_d  = cam_hit;
               resp_addr_d = cam_dout;
            end else if (fail_q) begin
               resp_hit_d  = 1'b0;
               resp_addr_d = {ADDR_W{1'b0}};
            end else begin
               resp_hit_d  = 1'b1;
               resp_addr_d = cam_addr_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Controller state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_LOOKUP;
         id_q         <= 1'b0;
         fail_q       <= 1'b0;
         cam_wen_q    <= 1'b0;
         cam_ren_q    <= 1'b0;
         cam_din_q    <= {DATA_W{1'b0}};
         cam_addr_q   <= {ADDR_W{1'b0}};
         resp_valid_q <= 1'b0;
         resp_id_q    <= 1'b0;
         resp_hit_q   <= 1'b0;
         resp_addr_q  <= {ADDR_W{1'b0}};
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         id_q         <= id_d;
         fail_q       <= fail_d;
         cam_wen_q    <= cam_wen_d;
         cam_ren_q    <= cam_ren_d;
         cam_din_q    <= cam_din_d;
         cam_addr_q   <= cam_addr_d;
         resp_valid_q <= resp_valid_d;
         resp_id_q    <= resp_id_d;
         resp_hit_q   <= resp_hit_d;
         resp_addr_q  <= resp_addr_d;
      end
   end

`ifdef CAM_AUTO_ALLOC_EN
   // Occupancy bitmap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q <= {N{1'b0}};
      end else begin
         occ_q <= occ_d;
      end
   end
`endif

   assign cam_wen    = cam_wen_q;
   assign cam_ren    = cam_ren_q;
   assign cam_din    = cam_din_q;
   assign cam_addr   = cam_addr_q;
   assign resp_valid = resp_valid_q;
   assign resp_id    = resp_id_q;
   assign resp_hit   = resp_hit_q;
   assign resp_addr  = resp_addr_q;

endmodule

// File: tb/tb_cam_access_ctrl.sv
// Self-checking bench for cam_access_ctrl with a behavioural CAM stub and a reference model.
// Honours CAM_AUTO_ALLOC_EN the same way as the design.
module tb_cam_access_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req = 2'b00;
   logic [1:0] op0 = 2'd0, op1 = 2'd0;
   logic [7:0] din0 = 8'd0, din1 = 8'd0;
   logic [3:0] addr0 = 4'd0, addr1 = 4'd0;
   logic [1:0] ready;
   logic       resp_valid, resp_id, resp_hit;
   logic [3:0] resp_addr;
   logic       cam_wen, cam_ren;
   logic [7:0] cam_din;
   logic [3:0] cam_addr;
   logic [3:0] cam_dout = 4'd0;
   logic       cam_hit = 1'b0;
   logic       cam_clear = 1'b0;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model state
   logic [7:0]  ref_val [16];
   logic [15:0] ref_vld = 16'h0;
   logic [15:0] ref_occ = 16'h0;

   // CAM stub state
   logic [7:0]  cmem [16];
   logic [15:0] cvld = 16'h0;

   cam_access_ctrl dut (
      .clk(clk), .rst(rst), .req(req),
      .op0(op0), .op1(op1), .din0(din0), .din1(din1),
      .addr0(addr0), .addr1(addr1), .ready(ready),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_hit(resp_hit), .resp_addr(resp_addr),
      .cam_wen(cam_wen), .cam_ren(cam_ren), .cam_din(cam_din), .cam_addr(cam_addr),
      .cam_dout(cam_dout), .cam_hit(cam_hit)
   );

   always #5 clk = ~clk;

   // CAM stub: registered write and priority (lowest address) search
   always @(posedge clk) begin
      logic       h;
      logic [3:0] a;
      if (cam_clear) begin
         cvld <= 16'h0;
      end else if (cam_wen) begin
         cmem[cam_addr] <= cam_din;
         cvld[cam_addr] <= 1'b1;
      end
      if (cam_ren) begin
         h = 1'b0;
         a = 4'd0;
         for (int k = 0; k < 16; k++) begin
            if (!h && cvld[k] && cmem[k] == cam_din) begin
               h = 1'b1;
               a = 4'(k);
            end
         end
         cam_hit  <= h;
         cam_dout <= a;
      end
   end

   // The CAM port must never carry a write and a read together
   always @(negedge clk) begin
      n_cmp++;
      assert (!(cam_wen === 1'b1 && cam_ren === 1'b1)) else begin
         n_fail++;
         $error("FAIL wen_ren_excl: observed wen=%0b ren=%0b required not both high", cam_wen, cam_ren);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Predict the response of one accepted request and update the model
   task automatic model(input logic [1:0] op, input logic [7:0] d, input logic [3:0] a,
                        output logic hit, output logic [3:0] ra, output logic w, output logic rd);
      hit = 1'b0; ra = 4'd0; w = 1'b0; rd = 1'b0;
      if (op == 2'd0 || op == 2'd3) begin
         rd = 1'b1;
         for (int i = 0; i < 16; i++)
            if (!hit && ref_vld[i] && ref_val[i] == d) begin hit = 1'b1; ra = 4'(i); end
      end else begin
         ra = a;
`ifdef CAM_AUTO_ALLOC_EN
         if (op == 2'd2) begin
            ra = 4'd0;
            for (int i = 0; i < 16; i++)
               if (!w && !ref_occ[i]) begin w = 1'b1; ra = 4'(i); end
         end else begin
            w = 1'b1;
         end
`else
         w = 1'b1;
`endif
         if (w) begin
            hit = 1'b1;
            ref_val[ra] = d;
            ref_vld[ra] = 1'b1;
            ref_occ[ra] = 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      req = 2'b00;
      rst = 1'b1;
      cam_clear = 1'b1;
      ref_vld = 16'h0;
      ref_occ = 16'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cam_clear = 1'b0;
   endtask

   // One request from client cl: accept, ISSUE checks, response two edges later
   task automatic txn(input int cl, input logic [1:0] op, input logic [7:0] d, input logic [3:0] a);
      int guard;
      logic eh, ew, er;
      logic [3:0] ea;
      if (cl == 0) begin op0 = op; din0 = d; addr0 = a; end
      else begin op1 = op; din1 = d; addr1 = a; end
      req[cl] = 1'b1;
      guard = 0;
      #1;
      while (!ready[cl] && guard < 20) begin @(negedge clk); #1; guard++; end
      chk("accept", 32'(ready[cl]), 32'd1);
      model(op, d, a, eh, ea, ew, er);
      @(posedge clk);
      #1 req[cl] = 1'b0;
      @(negedge clk);
      chk("issue_wen", 32'(cam_wen), 32'(ew));
      chk("issue_ren", 32'(cam_ren), 32'(er));
      if (ew) chk("issue_addr", 32'(cam_addr), 32'(ea));
      if (ew || er) chk("issue_din", 32'(cam_din), 32'(d));
      chk("rv_lat1", 32'(resp_valid), 32'd0);
      @(negedge clk);
      chk("rv_lat2", 32'(resp_valid), 32'd0);
      chk("wen_off", 32'(cam_wen | cam_ren), 32'd0);
      @(negedge clk);
      chk("rv_lat3", 32'(resp_valid), 32'd1);
      chk("resp_id", 32'(resp_id), 32'(cl));
      chk("resp_hit", 32'(resp_hit), 32'(eh));
      chk("resp_addr", 32'(resp_addr), 32'(ea));
   endtask

   initial begin
      int guard;
      int exp_id;
      logic eh, ew, er;
      logic [3:0] ea;

      do_reset();
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_rv", 32'(resp_valid), 32'd0);
      chk("rst_id", 32'(resp_id), 32'd0);
      chk("rst_hit", 32'(resp_hit), 32'd0);
      chk("rst_raddr", 32'(resp_addr), 32'd0);
      chk("rst_wen", 32'(cam_wen), 32'd0);
      chk("rst_ren", 32'(cam_ren), 32'd0);
      chk("rst_din", 32'(cam_din), 32'd0);
      chk("rst_caddr", 32'(cam_addr), 32'd0);

      // Basic write then lookup
      txn(0, 2'd1, 8'd10, 4'hC);
      txn(0, 2'd0, 8'd10, 4'h0);

      // Multiple matches: lowest address wins; then a miss
      txn(1, 2'd1, 8'd30, 4'hE);
      txn(0, 2'd1, 8'd30, 4'h0);
      txn(1, 2'd1, 8'd30, 4'h2);
      txn(0, 2'd0, 8'd30, 4'h0);
      chk("prio_addr", 32'(resp_addr), 32'h0);
      txn(1, 2'd0, 8'd99, 4'h0);

      // Both clients hold lookups: grants alternate starting with client 0
      do_reset();
      op0 = 2'd0; op1 = 2'd3; din0 = 8'h11; din1 = 8'h22;
      req = 2'b11;
      exp_id = 0;
      for (int k = 0; k < 6; k++) begin
         guard = 0;
         do begin @(negedge clk); guard++; end while (!resp_valid && guard < 20);
         chk("arb_rv", 32'(resp_valid), 32'd1);
         chk("arb_id", 32'(resp_id), 32'(exp_id));
         model(2'd0, exp_id == 0 ? din0 : din1, 4'd0, eh, ea, ew, er);
         chk("arb_hit", 32'(resp_hit), 32'(eh));
         exp_id = 1 - exp_id;
      end
      req = 2'b00;

`ifdef CAM_AUTO_ALLOC_EN
      do_reset();
      for (int k = 1; k <= 17; k++) begin
         txn(k % 2, 2'd2, 8'(k), 4'hF);
         chk("alloc_addr", 32'(resp_addr), k <= 16 ? 32'(k - 1) : 32'd0);
         chk("alloc_hit", 32'(resp_hit), k <= 16 ? 32'd1 : 32'd0);
      end
`else
      txn(0, 2'd2, 8'd5, 4'h7);
      txn(1, 2'd0, 8'd5, 4'h0);
      chk("alloc_as_write", 32'(resp_addr), 32'h7);
`endif

      // Reset during ISSUE of a write drops the write and every output
      do_reset();
      op1 = 2'd1; din1 = 8'hA5; addr1 = 4'h3; req = 2'b10;
      guard = 0;
      #1;
      while (!ready[1] && guard < 20) begin @(negedge clk); #1; guard++; end
      chk("mid_accept", 32'(ready[1]), 32'd1);
      @(posedge clk);
      #1 req = 2'b00;
      @(negedge clk);
      chk("mid_wen_on", 32'(cam_wen), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("mid_wen_off", 32'(cam_wen), 32'd0);
      chk("mid_ren", 32'(cam_ren), 32'd0);
      chk("mid_din", 32'(cam_din), 32'd0);
      chk("mid_caddr", 32'(cam_addr), 32'd0);
      chk("mid_rv", 32'(resp_valid), 32'd0);
      chk("mid_ready", 32'(ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      txn(0, 2'd0, 8'hA5, 4'h0);
      chk("lost_write", 32'(resp_hit), 32'd0);

      // Randomised mix against the reference model
      for (int k = 0; k < 40; k++) begin
         txn(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             8'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
